// File: rtl/prio_ctrl_pkg.sv
// Shared definitions for the sixteen-source priority interrupt controller.
// Contents:
//   N_SRC    - number of interrupt sources (fixed at 16)
//   ID_W     - width of a source index
//   MASK_RST - mask value after reset (every source blocked)
//   state_t  - handshake FSM states
//   onehot() - converts a source index to a one-hot source vector
package prio_ctrl_pkg;

  localparam int N_SRC = 16;
  localparam int ID_W  = 4;
  localparam logic [N_SRC-1:0] MASK_RST = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  function automatic logic [N_SRC-1:0] onehot(input logic [ID_W-1:0] id);
    logic [N_SRC-1:0] vec;
    vec = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/prio_enc16.sv
// Purely combinational 16-to-4 priority encoder. The highest set index wins,
// so bit 15 has the highest priority.
// Ports:
//   vec   in  16 : candidate sources (eligible vector)
//   id    out 4  : index of the highest set bit (0 when vec is empty)
//   valid out 1  : at least one bit of vec is set
module prio_enc16
  import prio_ctrl_pkg::*;
(
  input  logic [N_SRC-1:0] vec,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  // Ascending scan: a later (higher) set bit overrides any earlier one.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (vec[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_irq_ctrl.sv
// Sixteen-source priority interrupt controller.
// Requests are captured into a pending register (level or rising edge),
// gated by a software mask, and the highest-indexed eligible source is
// offered to the host through an irq/ack/eoi handshake. Only one source is
// in service at a time.
// Parameters:
//   EDGE_MODE   : 0 = level capture (pending set while req high),
//                 1 = rising-edge capture
// Ports:
//   clk         in  1  : clock, all state on the rising edge
//   rst_n       in  1  : asynchronous active-low reset
//   req         in  16 : raw request lines, synchronous to clk
//   mask_we     in  1  : mask write strobe
//   mask_wdata  in  16 : new mask value, bit=1 blocks the source
//   mask        out 16 : current mask register
//   pending     out 16 : current pending register
//   irq         out 1  : interrupt request to host (registered)
//   irq_id      out 4  : index of requested / in-service source (registered)
//   ack         in  1  : host accepts the current irq
//   eoi         in  1  : host signals end of service
//   in_service  out 1  : a source is being serviced (registered)
module prio_irq_ctrl
  import prio_ctrl_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] pending,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  input  logic             ack,
  input  logic             eoi,
  output logic             in_service
);

  logic [N_SRC-1:0] pending_reg;
  logic [N_SRC-1:0] mask_reg;
  logic [N_SRC-1:0] req_d_reg;
  state_t           state_reg;
  logic             irq_reg;
  logic [ID_W-1:0]  irq_id_reg;
  logic             in_service_reg;

  logic [N_SRC-1:0] set_bits;
  logic [N_SRC-1:0] clr_bits;
  logic [N_SRC-1:0] eligible;
  logic [ID_W-1:0]  winner;
  logic             any_eligible;

  // Capture: in edge mode only a low-to-high transition of req sets pending.
  assign set_bits = EDGE_MODE ? (req & ~req_d_reg) : req;

  // The accepted source is retired from pending on the ack edge. Capture is
  // OR-ed in afterwards so a simultaneous new request is not lost.
  assign clr_bits = (state_reg == REQ && ack) ? onehot(irq_id_reg) : '0;

  assign eligible = pending_reg & ~mask_reg;

  prio_enc16 u_enc (
    .vec   (eligible),
    .id    (winner),
    .valid (any_eligible)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
      mask_reg    <= MASK_RST;
      req_d_reg   <= '0;
    end else begin
      pending_reg <= (pending_reg & ~clr_bits) | set_bits;
      req_d_reg   <= req;
      if (mask_we) begin
        mask_reg <= mask_wdata;
      end
    end
  end

  // Handshake FSM. irq_id is latched only when leaving IDLE, so a newer
  // higher-priority arrival never preempts a request already offered, and
  // the id stays valid through SERVICE and after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      irq_reg        <= 1'b0;
      irq_id_reg     <= '0;
      in_service_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_eligible) begin
            state_reg  <= REQ;
            irq_id_reg <= winner;
            irq_reg    <= 1'b1;
          end
        end
        REQ: begin
          // ack is checked first, so it wins over a mask write that
          // removes the same source in the same cycle.
          if (ack) begin
            state_reg      <= SERVICE;
            irq_reg        <= 1'b0;
            in_service_reg <= 1'b1;
          end else if (!eligible[irq_id_reg]) begin
            // Source was masked while waiting: withdraw the request.
            state_reg <= IDLE;
            irq_reg   <= 1'b0;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state_reg      <= IDLE;
            in_service_reg <= 1'b0;
          end
        end
        default: begin
          state_reg      <= IDLE;
          irq_reg        <= 1'b0;
          in_service_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mask       = mask_reg;
  assign pending    = pending_reg;
  assign irq        = irq_reg;
  assign irq_id     = irq_id_reg;
  assign in_service = in_service_reg;

endmodule
